// File: rtl/demux_fixed_pipeline.sv
`default_nettype none
// ============================================================================
// Module   : demux_fixed_pipeline
// Brief    : Pipelined 1-to-N demultiplexer tree, one register level per digit
// Revision : 1.0 - initial release
// ============================================================================
module demux_fixed_pipeline #(
  parameter int WIDTH        = 4,
  parameter int OUTPUT_COUNT = 2,
  parameter int DEMUX_SIZE   = 2
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            in_valid,
  input  logic [$clog2(OUTPUT_COUNT)-1:0] sel,
  input  logic [WIDTH-1:0]                in,
  output logic [WIDTH*OUTPUT_COUNT-1:0]   out,
  output logic [OUTPUT_COUNT-1:0]         out_valid,
  output logic                            drop
);

  localparam int c_D      = $clog2(DEMUX_SIZE);
  localparam int c_SELW   = $clog2(OUTPUT_COUNT);
  localparam int c_L      = (c_SELW + c_D - 1) / c_D;
  localparam int c_PATHW  = c_L * c_D;
  localparam int c_LEAVES = 1 << c_PATHW;

  function automatic int level_nodes(input int k);
    return 1 << ((k + 1) * c_D);
  endfunction

  function automatic int level_off(input int k);
    int s;
    s = 0;
    for (int j = 0; j < k; j++) s += level_nodes(j);
    return s;
  endfunction

  // Source slot 0 is the input port; slot 1+i is inner tree node i.
  function automatic int par_idx(input int k, input int n);
    return (k == 0) ? 0 : 1 + level_off(k - 1) + (n >> c_D);
  endfunction

  localparam int c_INNER = level_off(c_L - 1);

  logic [c_INNER:0]            w_src_vld;
  logic [WIDTH-1:0]            w_src_data [c_INNER+1];
  logic [c_PATHW-1:0]          w_src_path [c_L];
  logic [c_LEAVES-1:0]         w_leaf_hit;
  logic                        w_drop_hit;

  logic [WIDTH*OUTPUT_COUNT-1:0] r_out;
  logic [OUTPUT_COUNT-1:0]       r_out_valid;
  logic                          r_drop;

  assign w_src_vld[0]  = in_valid;
  assign w_src_data[0] = in;
  assign w_src_path[0] = c_PATHW'(sel);

  if (c_L > 1) begin : g_tree
    logic [c_INNER-1:0] r_vld;
    logic [WIDTH-1:0]   r_data [c_INNER];
    logic [c_PATHW-1:0] r_path [c_L-1];
    logic [c_INNER-1:0] w_node_hit;

    assign w_src_vld[c_INNER:1] = r_vld;
    for (genvar i = 0; i < c_INNER; i++) begin : g_src_data
      assign w_src_data[i+1] = r_data[i];
    end
    for (genvar k = 1; k < c_L; k++) begin : g_src_path
      assign w_src_path[k] = r_path[k-1];
    end

    // A node loads when its parent holds the transfer and its prefix matches the path.
    always_comb begin
      w_node_hit = '0;
      for (int k = 0; k < c_L - 1; k++) begin
        for (int n = 0; n < level_nodes(k); n++) begin
          w_node_hit[level_off(k) + n] = w_src_vld[par_idx(k, n)] &&
            ((w_src_path[k] >> (c_PATHW - (k + 1) * c_D)) == c_PATHW'(n));
        end
      end
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r_vld <= '0;
        for (int i = 0; i < c_INNER; i++) r_data[i] <= '0;
        for (int k = 0; k < c_L - 1; k++) r_path[k] <= '0;
      end else begin
        r_vld <= w_node_hit;
        for (int k = 0; k < c_L - 1; k++) begin
          r_path[k] <= w_src_path[k];
          for (int n = 0; n < level_nodes(k); n++) begin
            if (w_node_hit[level_off(k) + n])
              r_data[level_off(k) + n] <= w_src_data[par_idx(k, n)];
          end
        end
      end
    end
  end

  // Leaves at or beyond OUTPUT_COUNT have no lane; hitting one means the word is dropped.
  always_comb begin
    w_leaf_hit = '0;
    w_drop_hit = 1'b0;
    for (int n = 0; n < c_LEAVES; n++) begin
      w_leaf_hit[n] = w_src_vld[par_idx(c_L - 1, n)] &&
                      (w_src_path[c_L-1] == c_PATHW'(n));
      if (n >= OUTPUT_COUNT) w_drop_hit = w_drop_hit | w_leaf_hit[n];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out       <= '0;
      r_out_valid <= '0;
      r_drop      <= 1'b0;
    end else begin
      r_out_valid <= w_leaf_hit[OUTPUT_COUNT-1:0];
      r_drop      <= w_drop_hit;
      for (int n = 0; n < OUTPUT_COUNT; n++) begin
        if (w_leaf_hit[n]) r_out[n*WIDTH +: WIDTH] <= w_src_data[par_idx(c_L - 1, n)];
      end
    end
  end

  assign out       = r_out;
  assign out_valid = r_out_valid;
  assign drop      = r_drop;

endmodule
`default_nettype wire

// File: tb/tb_demux_fixed_pipeline.sv
`default_nettype none
// ============================================================================
// Module   : tb_demux_fixed_pipeline
// Brief    : Checks two demux trees (fan-out 2 and 4) against a delay-queue model
// Revision : 1.0 - initial release
// ============================================================================
module tb_demux_fixed_pipeline;

  typedef struct {
    int         due;
    int         lane;
    logic [3:0] d;
  } xfer_t;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [3:0]  sel;
  logic [3:0]  din;
  logic [39:0] out_a, out_b;
  logic [9:0]  ov_a, ov_b;
  logic        drop_a, drop_b;

  int          n_vec;
  int          n_err;
  int          edge_cnt;
  int          lat [2];
  xfer_t       q [2][$];
  logic [39:0] exp_out [2];
  logic [9:0]  exp_ov [2];
  logic        exp_drop [2];

  demux_fixed_pipeline #(.WIDTH(4), .OUTPUT_COUNT(10), .DEMUX_SIZE(2)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .sel(sel), .in(din),
    .out(out_a), .out_valid(ov_a), .drop(drop_a)
  );

  demux_fixed_pipeline #(.WIDTH(4), .OUTPUT_COUNT(10), .DEMUX_SIZE(4)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .sel(sel), .in(din),
    .out(out_b), .out_valid(ov_b), .drop(drop_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, act, exp, edge_cnt);
    end
  endtask

  // A transfer accepted at edge e appears on the outputs right after edge e+L-1.
  task automatic model_edge();
    xfer_t t;
    edge_cnt++;
    for (int m = 0; m < 2; m++) begin
      exp_ov[m]   = '0;
      exp_drop[m] = 1'b0;
      if (!rst_n) begin
        q[m].delete();
        exp_out[m] = '0;
      end else begin
        if (in_valid) q[m].push_back('{due: edge_cnt + lat[m] - 1, lane: int'(sel), d: din});
        if (q[m].size() > 0 && q[m][0].due == edge_cnt) begin
          t = q[m].pop_front();
          if (t.lane < 10) begin
            exp_ov[m][t.lane]         = 1'b1;
            exp_out[m][t.lane*4 +: 4] = t.d;
          end else begin
            exp_drop[m] = 1'b1;
          end
        end
      end
    end
  endtask

  task automatic cycle(input logic rn, input logic v, input logic [3:0] s, input logic [3:0] d);
    rst_n    = rn;
    in_valid = v;
    sel      = s;
    din      = d;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("a_out_valid", ov_a, exp_ov[0]);
    check("a_drop", drop_a, exp_drop[0]);
    check("a_out", out_a, exp_out[0]);
    check("b_out_valid", ov_b, exp_ov[1]);
    check("b_drop", drop_b, exp_drop[1]);
    check("b_out", out_b, exp_out[1]);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 4'($urandom), 4'($urandom));
  endtask

  initial begin
    n_vec    = 0;
    n_err    = 0;
    edge_cnt = 0;
    lat[0]   = 4;
    lat[1]   = 2;
    for (int m = 0; m < 2; m++) begin
      exp_out[m]  = '0;
      exp_ov[m]   = '0;
      exp_drop[m] = 1'b0;
    end
    rst_n    = 1'b0;
    in_valid = 1'b0;
    sel      = '0;
    din      = '0;

    // Reset with a live-looking request that must be ignored
    cycle(1'b0, 1'b1, 4'd3, 4'hF);
    cycle(1'b0, 1'b1, 4'd3, 4'hF);
    check("reset_out_a", out_a, 64'h0);
    check("reset_out_b", out_b, 64'h0);
    idle(6);

    // Single transfer to lane 3
    cycle(1'b1, 1'b1, 4'd3, 4'hA);
    idle(6);
    check("single_lane3_a", out_a[15:12], 64'hA);
    check("single_others_a", {out_a[39:16], out_a[11:0]}, 64'h0);

    // Back-to-back sweep over every lane
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b1, 4'(i), 4'(i));
    idle(6);
    check("sweep_out_a", out_a, 64'h9876543210);
    check("sweep_out_b", out_b, 64'h9876543210);

    // Out-of-range destinations
    cycle(1'b1, 1'b1, 4'd12, 4'h5);
    cycle(1'b1, 1'b1, 4'd11, 4'h7);
    cycle(1'b1, 1'b1, 4'd15, 4'h1);
    idle(6);
    check("drop_keeps_out_a", out_a, 64'h9876543210);

    // Reset while a transfer is in flight
    cycle(1'b1, 1'b1, 4'd7, 4'hC);
    cycle(1'b1, 1'b0, 4'd0, 4'h0);
    cycle(1'b0, 1'b0, 4'd0, 4'h0);
    idle(6);
    check("flushed_lane7_a", out_a[31:28], 64'h0);

    // Short-latency tree corner cases, then idle with random junk on sel/in
    cycle(1'b1, 1'b1, 4'd9, 4'h6);
    cycle(1'b1, 1'b1, 4'd11, 4'h3);
    idle(8);
    check("lane9_b", out_b[39:36], 64'h6);

    // Randomised traffic with occasional resets
    for (int i = 0; i < 600; i++) begin
      cycle(($urandom_range(0, 49) != 0), 1'($urandom_range(0, 1)),
            4'($urandom_range(0, 15)), 4'($urandom));
    end
    idle(6);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
